// File: rtl/directory_wb_buffer.sv
// In-order writeback FIFO feeding the directory data store write port, with read forward/stall detection.
// Optional build macro DIR_WB_COALESCE_EN merges writebacks to an already-queued index in place.
module directory_wb_buffer #(
    parameter int CL_SIZE = 4,
    parameter int IDX_CNT = 512,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_valid,
    input  logic [$clog2(IDX_CNT)-1:0]   wb_idx,
    input  logic [CL_SIZE*8-1:0]         wb_data,
    output logic                         wb_ready,
    input  logic [2:0]                   operation,
    input  logic [$clog2(IDX_CNT)-1:0]   idx,
    input  logic                         drain_hold,
    output logic                         alloc,
    output logic [$clog2(IDX_CNT)-1:0]   idx_in_wb,
    output logic [CL_SIZE*8-1:0]         cl_in_wb,
    output logic                         st_fwd,
    output logic                         rd_stall,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int IW = $clog2(IDX_CNT);
    localparam int DW = CL_SIZE * 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic           rst_n_q;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [DEPTH-1:0] vld;
    logic [IW-1:0]  idx_mem  [DEPTH];
    logic [DW-1:0]  data_mem [DEPTH];

    logic           hit;
    logic [PW-1:0]  hit_ptr;
    logic           full;
    logic           push;
    logic           push_new;

    always_comb begin
        alloc     = (count != '0) && !drain_hold;
        idx_in_wb = idx_mem[head];
        cl_in_wb  = data_mem[head];
        st_fwd    = alloc && (operation != 3'd0) && (idx == idx_in_wb);

        // The head is excluded only while it is actually leaving this cycle.
        rd_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (idx_mem[i] == idx) && !(alloc && (head == PW'(i))))
                rd_stall = 1'b1;
        end
        rd_stall = rd_stall && (operation != 3'd0);

        hit     = 1'b0;
        hit_ptr = '0;
`ifdef DIR_WB_COALESCE_EN
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && vld[i] && (idx_mem[i] == wb_idx) && !(alloc && (head == PW'(i)))) begin
                hit     = 1'b1;
                hit_ptr = PW'(i);
            end
        end
`endif
        full     = (count == CW'(DEPTH));
        wb_ready = rst_n_q && (!full || hit);
        push     = wb_valid && wb_ready;
        push_new = push && !hit;
    end

    always_ff @(posedge clk) begin
        rst_n_q <= rst_n;
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push_new) begin
                vld[tail]      <= 1'b1;
                idx_mem[tail]  <= wb_idx;
                data_mem[tail] <= wb_data;
                tail           <= tail + PW'(1);
            end
            if (push && hit)
                data_mem[hit_ptr] <= wb_data;
            if (alloc) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            if (push_new && !alloc)
                count <= count + CW'(1);
            else if (!push_new && alloc)
                count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_directory_wb_buffer.sv
// Directed bench for directory_wb_buffer with a queue-based reference model checked every cycle.
module tb_directory_wb_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [8:0]  idx;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [8:0]  wb_idx;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic [2:0]  operation;
    logic [8:0]  idx;
    logic        drain_hold;
    logic        alloc;
    logic [8:0]  idx_in_wb;
    logic [31:0] cl_in_wb;
    logic        st_fwd;
    logic        rd_stall;
    logic [2:0]  count;

    directory_wb_buffer #(.CL_SIZE(4), .IDX_CNT(512), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .wb_ready(wb_ready), .operation(operation), .idx(idx), .drain_hold(drain_hold),
        .alloc(alloc), .idx_in_wb(idx_in_wb), .cl_in_wb(cl_in_wb), .st_fwd(st_fwd),
        .rd_stall(rd_stall), .count(count)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q[$];
    ent_t drained[$];
    logic m_rstq = 1'b0;
    bit   started = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Index of a queued, non-departing entry with the given idx, or -1.
    function automatic int find_idx(input logic [8:0] k, input bit skip_head);
        for (int j = (skip_head ? 1 : 0); j < q.size(); j++)
            if (q[j].idx == k) return j;
        return -1;
    endfunction

    function automatic bit exp_ready();
        int m;
        m = -1;
`ifdef DIR_WB_COALESCE_EN
        m = find_idx(wb_idx, (q.size() != 0) && !drain_hold);
`endif
        return m_rstq && ((q.size() != DEPTH) || (m >= 0));
    endfunction

    always @(posedge clk) begin
        bit   a_e;
        bit   rdy;
        int   m;
        ent_t e;
        a_e = (q.size() != 0) && !drain_hold;
        rdy = exp_ready();
        m   = -1;
`ifdef DIR_WB_COALESCE_EN
        m = find_idx(wb_idx, a_e);
`endif
        if (!rst_n) begin
            q.delete();
        end else begin
            if (wb_valid && rdy) begin
                if (m >= 0) begin
                    e = q[m]; e.data = wb_data; q[m] = e;
                end else begin
                    e.idx = wb_idx; e.data = wb_data; q.push_back(e);
                end
            end
            if (a_e) begin
                drained.push_back(q[0]);
                void'(q.pop_front());
            end
        end
        m_rstq  = rst_n;
        started = 1;
    end

    always @(negedge clk) begin
        bit a_e;
        if (started) begin
            a_e = (q.size() != 0) && !drain_hold;
            chk("count", 64'(count), 64'(q.size()));
            chk("wb_ready", 64'(wb_ready), 64'(exp_ready()));
            chk("alloc", 64'(alloc), 64'(a_e));
            chk("rd_stall", 64'(rd_stall),
                64'((operation != 0) && (find_idx(idx, a_e) >= 0)));
            if (q.size() != 0) begin
                chk("idx_in_wb", 64'(idx_in_wb), 64'(q[0].idx));
                chk("cl_in_wb", 64'(cl_in_wb), 64'(q[0].data));
                chk("st_fwd", 64'(st_fwd), 64'(a_e && (operation != 0) && (idx == q[0].idx)));
            end else begin
                chk("st_fwd_empty", 64'(st_fwd), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
        operation = '0; idx = '0; drain_hold = 1'b0;
        step();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ready", 64'(wb_ready), 64'(0));
        chk("rst_alloc", 64'(alloc), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("ready_up", 64'(wb_ready), 64'(1));

        // Single writeback, one-cycle latency
        drained.delete();
        wb_valid = 1'b1; wb_idx = 9'h05; wb_data = 32'hDEADBEEF;
        step();
        wb_valid = 1'b0;
        chk("t1_alloc", 64'(alloc), 64'(1));
        chk("t1_idx", 64'(idx_in_wb), 64'h05);
        chk("t1_data", 64'(cl_in_wb), 64'hDEADBEEF);
        step();
        chk("t1_count", 64'(count), 64'(0));
        chk("t1_log", 64'(drained.size() == 1 && drained[0].idx == 9'h05 && drained[0].data == 32'hDEADBEEF), 64'(1));

        // Fill to full, refuse the fifth, then drain in order
        drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_idx = 9'(i); wb_data = 32'h100 + 32'(i);
            step();
        end
        chk("t2_full_count", 64'(count), 64'(4));
        chk("t2_full_ready", 64'(wb_ready), 64'(0));
        wb_idx = 9'h09;
        step();
        chk("t2_refuse", 64'(count), 64'(4));
        wb_valid = 1'b0; drain_hold = 1'b0;
        drained.delete();
        for (int i = 0; i < 4; i++) step();
        chk("t2_ndrain", 64'(drained.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < drained.size()) chk("t2_order", 64'(drained[i].idx), 64'(i + 1));
        chk("t2_empty", 64'(count), 64'(0));

        // Forward vs stall
        drain_hold = 1'b1;
        wb_valid = 1'b1; wb_idx = 9'h10; wb_data = 32'hA0A0; step();
        wb_idx = 9'h20; wb_data = 32'hB0B0; step();
        wb_valid = 1'b0; drain_hold = 1'b0; operation = 3'd1; idx = 9'h10;
        #1;
        chk("t3_fwd", 64'(st_fwd), 64'(1));
        chk("t3_nostall", 64'(rd_stall), 64'(0));
        idx = 9'h20;
        #1;
        chk("t3_stall", 64'(rd_stall), 64'(1));
        chk("t3_nofwd", 64'(st_fwd), 64'(0));
        step();
        operation = 3'd0;
        step();

        // Push and pop together at count 2 across pointer wrap
        drained.delete();
        drain_hold = 1'b1;
        wb_valid = 1'b1; wb_idx = 9'h40; wb_data = 32'h4000; step();
        wb_idx = 9'h41; wb_data = 32'h4001; step();
        drain_hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wb_idx = 9'h42 + 9'(k); wb_data = 32'h4002 + 32'(k);
            step();
            chk("t4_count", 64'(count), 64'(2));
        end
        wb_valid = 1'b0;
        step(); step();
        chk("t4_ndrain", 64'(drained.size()), 64'(12));
        for (int k = 0; k < 12; k++)
            if (k < drained.size()) chk("t4_order", 64'(drained[k].idx), 64'h40 + 64'(k));

        // Reset with entries queued
        drain_hold = 1'b1;
        wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_idx = 9'h50 + 9'(i); wb_data = 32'h5000 + 32'(i); step();
        end
        wb_valid = 1'b0;
        chk("t5_pre", 64'(count), 64'(3));
        rst_n = 1'b0; drain_hold = 1'b0;
        drained.delete();
        step();
        chk("t5_count", 64'(count), 64'(0));
        chk("t5_alloc", 64'(alloc), 64'(0));
        rst_n = 1'b1;
        step(); step(); step();
        chk("t5_nostale", 64'(drained.size()), 64'(0));
        wb_valid = 1'b1; wb_idx = 9'h60; wb_data = 32'h6000; step();
        wb_valid = 1'b0; step();
        chk("t5_after", 64'(drained.size() == 1 && drained[0].idx == 9'h60), 64'(1));

`ifdef DIR_WB_COALESCE_EN
        // Same index merges into the existing entry
        drained.delete();
        drain_hold = 1'b1;
        wb_valid = 1'b1; wb_idx = 9'h30; wb_data = 32'hAAAA_0001; step();
        wb_idx = 9'h31; wb_data = 32'hCCCC_0003; step();
        wb_idx = 9'h30; wb_data = 32'hBBBB_0002; step();
        wb_valid = 1'b0;
        chk("t6_count", 64'(count), 64'(2));
        drain_hold = 1'b0;
        step(); step();
        chk("t6_n", 64'(drained.size()), 64'(2));
        if (drained.size() == 2) begin
            chk("t6_e0", 64'(drained[0]), 64'({9'h30, 32'hBBBB_0002}));
            chk("t6_e1", 64'(drained[1]), 64'({9'h31, 32'hCCCC_0003}));
        end
`endif
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/directory_wb_buffer.md
# directory_wb_buffer

Writeback-side producer for the directory data store. Accepts cache-line writebacks from the directory controller over a valid/ready handshake, holds them in a small in-order FIFO, and drains one entry per cycle into the data store's writeback port (`alloc`, `idx_in_wb`, `cl_in_wb`). It watches the data store's read request (`operation`, `idx`) and drives `st_fwd` when a read targets the line being written that cycle. It flags `rd_stall` when the read hits an older queued writeback that the data store cannot yet supply.

## Interface
- `CL_SIZE`, 4: cache-line size in bytes; data width is `CL_SIZE*8`.
- `IDX_CNT`, 512: directory index count; index width is `$clog2(IDX_CNT)`.
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.

- `clk` in 1: single clock; everything is sampled on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `wb_valid` in 1: writeback request valid.
- `wb_idx` in `$clog2(IDX_CNT)`: writeback index.
- `wb_data` in `CL_SIZE*8`: writeback line.
- `wb_ready` out 1: buffer can accept a request.
- `operation` in 3: data store read opcode; non-zero means a read is active.
- `idx` in `$clog2(IDX_CNT)`: data store read index.
- `drain_hold` in 1: data store write port unavailable; blocks the drain this cycle.
- `alloc` out 1: write strobe to the data store.
- `idx_in_wb` out `$clog2(IDX_CNT)`: write index (head entry).
- `cl_in_wb` out `CL_SIZE*8`: write data (head entry).
- `st_fwd` out 1: data store returns `cl_in_wb` instead of the array value.
- `rd_stall` out 1: the read hits a queued, non-draining entry; the requester must replay.
- `count` out `$clog2(DEPTH)+1`: number of valid entries.

## Operation
- Storage: `DEPTH` entries, each holding {valid, idx, data}. Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `count` is registered.
- Enqueue:
  - Fires when `wb_valid && wb_ready`.
  - `wb_ready = rst_n_q && (count != DEPTH)`. It is combinational from registered state and is not affected by a same-cycle drain.
  - The entry is written at tail, and tail increments.
- Drain:
  - `alloc = (count != 0) && !drain_hold`.
  - `idx_in_wb` and `cl_in_wb` always present the head entry; they are don't-care when `count==0`.
  - When `alloc` is high, the head is popped at the edge.
- Forward: `st_fwd = alloc && (operation != 0) && (idx == idx_in_wb)`.
- Stall:
  - `rd_stall = (operation != 0)` and `idx` matches any valid entry other than the entry being drained this cycle.
  - When `alloc` is low, this includes the head.
  - `rd_stall` and `st_fwd` may both be high when duplicate indices are queued. The requester must treat `rd_stall` as dominant.
- Ordering: writebacks reach the data store strictly in acceptance order, except for coalescing (see Configuration).
- Simultaneous enqueue and drain: `count` is unchanged, and both pointers advance.
- Enqueue with `count==0`: there is no bypass. The entry is drained no earlier than the following cycle.
- Reset:
  - While `rst_n` is low at an edge: pointers are 0, `count` is 0, and all valid bits are cleared.
  - Data contents are not reset.
  - Any in-flight entries are discarded.

## Timing
- Enqueue-to-`alloc` latency is 1 cycle minimum: accepted at edge N, `alloc` high in cycle N→N+1 if the buffer was empty and `drain_hold` is low.
- Throughput: 1 enqueue and 1 drain per cycle.
- `alloc`, `st_fwd`, `rd_stall` and `wb_ready` are combinational from registered state plus the current inputs. There is no combinational path from `wb_valid` to any output.
- Reset values, observed in the cycle after the reset edge while `rst_n` is still low:
  - `alloc` 0, `st_fwd` 0, `count` 0.
  - `wb_ready` 0, because it is gated by `rst_n_q`, a register of `rst_n`.
  - `rd_stall` 0.
- `wb_ready` rises in the first cycle after `rst_n` has been sampled high.

## Configuration
- Macro: `DIR_WB_COALESCE_EN`.
- Defined:
  - An enqueue whose `wb_idx` matches a valid entry that is not draining this cycle overwrites that entry's data in place. No new slot is allocated, and tail and `count` are unchanged.
  - Coalescing is allowed even when `count==DEPTH`; in that case `wb_ready` is high if a match exists.
  - A match against the head while it is draining allocates a new entry instead.
- Undefined: every accepted request allocates a new entry, and duplicate indices may coexist.

## Test plan
- Reset then single writeback: after reset, enqueue idx 0x05 with data 0xDEADBEEF → `alloc`=1 one cycle later with `idx_in_wb`=0x05 and `cl_in_wb`=0xDEADBEEF, and `count` returns to 0.
- Fill to full: with `drain_hold`=1, enqueue 4 entries → `wb_ready`=0 and `count`=4. A 5th `wb_valid` is not accepted. Releasing the hold drains idx in order, one per cycle.
- Forward versus stall: queue idx 0x10 then 0x20 and issue read `operation`=1, `idx`=0x10 while the head drains → `st_fwd`=1 and `rd_stall`=0. A read of idx 0x20 in the same cycle → `rd_stall`=1 and `st_fwd`=0.
- Simultaneous push and pop at `count`=2 → `count` stays 2 and order is preserved across pointer wrap, checked over 10 such cycles.
- Reset mid-operation: with 3 entries queued, pull `rst_n` low for 1 cycle → `count`=0 and `alloc`=0, and no stale entry is ever drained afterwards.
- With `DIR_WB_COALESCE_EN`: under `drain_hold`, enqueue idx 0x30 (data A), idx 0x31, then idx 0x30 (data B) → `count`=2, and the drain emits 0x30 with data B, then 0x31.
